// File: rtl/i2c_bus_arb.sv
// Round-robin arbiter sharing one I2C master engine between N requesters.
// Grants only after tBUF of bus-free time; revokes on release, al or timeout.
module i2c_bus_arb #(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int US       = 1,
    parameter int TBUF_US  = 5,
    parameter int HOLD_MAX = 65535
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           bby,
    input  logic           al,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_vld,
    output logic [N-1:0]   lost,
    output logic [N-1:0]   tmo,
    output logic           bus_free
);

    localparam int TBUF = TBUF_US * US;
    localparam int FW   = (TBUF > 0) ? $clog2(TBUF + 1) : 1;
    localparam int HW   = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    localparam logic [FW-1:0]  FINIT = FW'(TBUF);
    localparam logic [HW-1:0]  HLAST = HW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
    localparam logic [IDW-1:0] PINIT = IDW'(N - 1);
    localparam logic [N-1:0]   ONE   = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state, state_n;
    logic [FW-1:0]  fcnt;
    logic [HW-1:0]  hcnt, hcnt_n;
    logic [IDW-1:0] ptr, ptr_n;
    logic [IDW-1:0] win;
    logic [IDW-1:0] gnt_id_n;
    logic [N-1:0]   gnt_n, lost_n, tmo_n;
    logic           found;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fcnt     <= FINIT;
            bus_free <= 1'b0;
        end else begin
            if (bby)
                fcnt <= FINIT;
            else if (fcnt != '0)
                fcnt <= fcnt - 1'b1;
            bus_free <= !bby && (fcnt == '0);
        end
    end

    // First requester after the pointer wins; the pointer itself is checked last.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!found && req[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                win   = IDW'((int'(ptr) + k) % N);
            end
        end
    end

    always_comb begin
        state_n  = state;
        gnt_n    = gnt;
        gnt_id_n = gnt_id;
        ptr_n    = ptr;
        hcnt_n   = hcnt;
        lost_n   = '0;
        tmo_n    = '0;
        unique case (state)
            IDLE: begin
                if (bus_free && (req != '0)) begin
                    gnt_n    = ONE << win;
                    gnt_id_n = win;
                    hcnt_n   = '0;
                    state_n  = GRANT;
                end
            end
            GRANT: begin
                if (hcnt != '1)
                    hcnt_n = hcnt + 1'b1;
                if (!req[gnt_id]) begin
                    gnt_n   = '0;
                    ptr_n   = gnt_id;
                    state_n = IDLE;
                end else if (al) begin
                    // Loser keeps its priority so it retries first.
                    gnt_n   = '0;
                    lost_n  = gnt;
                    state_n = IDLE;
                end else if ((HOLD_MAX != 0) && (hcnt == HLAST)) begin
                    gnt_n   = '0;
                    tmo_n   = gnt;
                    ptr_n   = gnt_id;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            gnt_vld <= 1'b0;
            lost    <= '0;
            tmo     <= '0;
            ptr     <= PINIT;
            hcnt    <= '0;
        end else begin
            state   <= state_n;
            gnt     <= gnt_n;
            gnt_id  <= gnt_id_n;
            gnt_vld <= |gnt_n;
            lost    <= lost_n;
            tmo     <= tmo_n;
            ptr     <= ptr_n;
            hcnt    <= hcnt_n;
        end
    end

endmodule

// File: doc/i2c_bus_arb.md
Name: i2c_bus_arb

Overview:
- Shares one I2C master engine between N local requesters.
- Grants the engine, one requester at a time, in round-robin order.
- Issues a grant only after the bus has been free for the I2C bus-free time (tBUF), using the bus-busy flag from the bus-state detector.
- Revokes a grant on requester release, on arbitration loss reported by the engine, or on hold timeout.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, width of gnt_id; N <= 2**IDW.
- US, 1, clock cycles per microsecond; same meaning as in the bus detector.
- TBUF_US, 5, bus-free time in microseconds; TBUF = TBUF_US*US cycles.
- HOLD_MAX, 65535, maximum cycles a grant may be held; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- req  in  N  per-requester request; level, held high for the whole transaction.
- bby  in  1  bus busy, from the bus-state detector.
- al  in  1  arbitration-lost pulse from the master engine.
- gnt  out  N  one-hot grant; all zero when idle.
- gnt_id  out  IDW  index of the current or last winner.
- gnt_vld  out  1  OR of gnt.
- lost  out  N  one-cycle pulse to the requester whose grant was revoked by al.
- tmo  out  N  one-cycle pulse to the requester whose grant was revoked by timeout.
- bus_free  out  1  bus idle and tBUF elapsed.

Behaviour:
- All outputs are registered.
- Reset, asynchronous while rst=0:
  - gnt=0, gnt_vld=0, gnt_id=0, lost=0, tmo=0, bus_free=0.
  - Free counter fcnt=TBUF.
  - Priority pointer ptr=N-1, so requester 0 has first priority.
  - Hold counter hcnt=0. State IDLE.
- Free counter (runs in every state):
  - bby=1: fcnt<=TBUF.
  - bby=0 and fcnt>0: fcnt<=fcnt-1.
  - bus_free <= (bby==0 && fcnt==0), registered. Free therefore asserts TBUF+1 cycles after bby falls.
  - TBUF=0: bus_free follows !bby with 1 cycle of latency.
- Round-robin select: the first i with req[i]=1, searching ptr+1, ptr+2, … modulo N.
- State IDLE:
  - If bus_free=1 and req!=0: winner w is registered; next cycle gnt[w]=1, gnt_id=w, gnt_vld=1, hcnt=0, ptr unchanged. Go to GRANT.
  - Otherwise remain in IDLE.
  - Latency: req plus a registered free bus at cycle k gives gnt at cycle k+1.
- State GRANT (winner w):
  - hcnt increments each cycle and saturates.
  - Checks below are evaluated in order; the first match wins.
  - (1) req[w]=0: gnt<=0, ptr<=w, go to IDLE. No pulse is issued, even if al or timeout fires in the same cycle.
  - (2) al=1: gnt<=0, lost[w] pulses for 1 cycle, ptr unchanged (w retains priority for retry), go to IDLE.
  - (3) HOLD_MAX!=0 and hcnt==HOLD_MAX-1: gnt<=0, tmo[w] pulses for 1 cycle, ptr<=w, go to IDLE.
- A new grant is never issued in the cycle a grant drops. The earliest regrant is 1 cycle after gnt falls, and only if bus_free=1.
  - A STOP by the previous holder sets bby, so the bus-free time is enforced automatically.
  - If the holder released without touching the bus, bus_free is still 1 and regrant follows after 1 idle cycle.
- bby rising during IDLE:
  - bus_free clears next cycle.
  - A grant already decided in the same cycle is still issued; the engine's own arbitration resolves the collision, with al as the escape.
- Requests from non-winners while in GRANT are ignored. gnt stays one-hot or all zero.
- gnt_id holds the last winner while idle.
- req changes in IDLE are sampled each cycle; no latching.
- A mid-operation reset drops the grant immediately (asynchronously). After reset the bus must be seen free for TBUF again before any grant.

Test Plan:
- Free time: US=1, TBUF_US=5, bby held low from reset, req=0001 → gnt=0001 at the 7th clk after reset release, gnt_id=0. Hold req for 10 cycles, drop → gnt=0 one cycle later.
- Round-robin: req=1111 held, each winner drops req 3 cycles after its grant and re-raises it 2 cycles later → grant order 0,1,2,3,0. Each new gnt appears 2 cycles after the previous req drop.
- Bus-free enforcement: after a grant, pulse bby high for 20 cycles while the holder keeps req, then drop req. Hold bby low; second request pending → next gnt exactly 7 cycles after bby falls, not before.
- Arbitration loss: req=0110, winner 1, al pulse → lost=0010 for 1 cycle, gnt=0. Once bus_free, requester 1 wins again over 2.
- Timeout: HOLD_MAX=8, req=0001 held → gnt high for exactly 8 cycles, tmo=0001 pulse, then req=0011 → requester 1 granted next. Also: al and req drop in the same cycle → no lost pulse.
- Reset mid-grant: rst low while gnt=0100 → gnt=0 without a clock edge. After rst high, bus_free=0 for TBUF cycles and requester 0 has priority.
